// File: rtl/ifetch_seq_if.sv
// Fetch-sequencer bus: redirect input, icache request/response channel and
// instruction-queue push/pop/flush/credit signals.
interface ifetch_seq_if #(
    parameter int unsigned IQ_DEPTH = 8
);
    localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

    logic          redirect_i;
    logic [63:0]   redirect_pc_i;
    logic          icache_req_o;
    logic [63:0]   icache_addr_o;
    logic          icache_ready_i;
    logic          icache_valid_i;
    logic [63:0]   icache_data_i;
    logic          iq_wr_o;
    logic [63:0]   iq_data_o;
    logic          iq_rd_i;
    logic          iq_flush_o;
    logic [CW-1:0] credits_o;

    modport master (
        input  redirect_i, redirect_pc_i, icache_ready_i, icache_valid_i,
               icache_data_i, iq_rd_i,
        output icache_req_o, icache_addr_o, iq_wr_o, iq_data_o, iq_flush_o,
               credits_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, icache_ready_i, icache_valid_i,
               icache_data_i, iq_rd_i,
        input  icache_req_o, icache_addr_o, iq_wr_o, iq_data_o, iq_flush_o,
               credits_o
    );
endinterface

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: fetches 8-byte lines from the icache one at a
// time and pushes them into a credit-tracked instruction queue.
module ifetch_seq #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned IQ_DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ifetch_seq_if.master bus
);
    localparam int unsigned    CW   = $clog2(IQ_DEPTH) + 1;
    localparam logic [CW-1:0]  FULL = CW'(IQ_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [63:0]   line_q, line_d;
    logic          flush_q, flush_d;

    logic          push;
    logic          pop;
    logic [CW:0]   credit_sum;

    // A line needs two free entries; redirect and reset both veto the write.
    assign push = (state_q == S_PUSH) && (credits_q >= CW'(2))
                  && !bus.redirect_i && !rst_i;
    assign pop  = bus.iq_rd_i && !flush_q;

    assign bus.icache_req_o  = !rst_i && (state_q == S_REQ);
    assign bus.icache_addr_o = rst_i ? RESET_PC : pc_q;
    assign bus.iq_wr_o       = push;
    assign bus.iq_data_o     = push ? line_q : '0;
    assign bus.iq_flush_o    = !rst_i && flush_q;
    assign bus.credits_o     = rst_i ? FULL : credits_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        line_d     = line_q;
        flush_d    = 1'b0;
        credit_sum = {1'b0, credits_q} + (CW+1)'(pop)
                     - (push ? (CW+1)'(2) : '0);
        credits_d  = (credit_sum > {1'b0, FULL}) ? FULL : credit_sum[CW-1:0];

        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (bus.icache_ready_i) state_d = S_WAIT;
            S_WAIT: begin
                if (bus.icache_valid_i) begin
                    line_d  = bus.icache_data_i;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (push) begin
                    pc_d    = pc_q + 64'd8;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: if (bus.icache_valid_i) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        if (bus.redirect_i) begin
            pc_d      = bus.redirect_pc_i & ~64'h7;
            credits_d = FULL;
            line_d    = '0;
            flush_d   = 1'b1;
            // A response landing alongside the redirect retires the only
            // outstanding request, so DRAIN is entered only if one remains.
            case (state_q)
                S_REQ:   state_d = bus.icache_ready_i ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = bus.icache_valid_i ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = bus.icache_valid_i ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            credits_q <= FULL;
            line_q    <= '0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            credits_q <= credits_d;
            line_q    <= line_d;
            flush_q   <= flush_d;
        end
    end
endmodule

// File: tb/tb_ifetch_seq.sv
// Bench for ifetch_seq: randomized icache/queue/redirect traffic checked every
// cycle against a line-level behavioural model, plus directed literal checks.
module tb_ifetch_seq;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int unsigned D        = 8;
    localparam int W_WR      = 0;
    localparam int W_REQ     = 1;
    localparam int W_WAITING = 2;
    localparam int W_PUSH2   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_seq_if #(.IQ_DEPTH(D)) bus();

    ifetch_seq #(.RESET_PC(RESET_PC), .IQ_DEPTH(D)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: what the fetcher holds, in terms of lines and requests.
    bit          m_idle  = 1'b1;
    logic [63:0] m_pc    = RESET_PC;
    int          m_cred  = D;
    bit          m_have  = 1'b0;
    logic [63:0] m_line  = '0;
    bit          m_out   = 1'b0;
    bit          m_drain = 1'b0;
    bit          m_flush = 1'b0;

    // Stimulus knobs and directed overrides.
    int          k_rdy_pct = 100, k_rd_pct = 0, k_redir_pct = 0;
    int          k_lat_min = 0, k_lat_max = 0;
    bit          k_rd_with_push = 1'b0, k_fixed = 1'b1;
    logic [63:0] k_data = 64'hAAAA_BBBB_CCCC_DDDD;
    bit          f_rst = 1'b0, f_redir = 1'b0, f_rd = 1'b0;
    logic [63:0] f_rpc = '0;

    // Icache responder: one request at a time, fixed or random latency.
    bit          e_busy = 1'b0;
    int          e_lat  = 0;
    logic [63:0] e_data = '0;

    bit          s_req, s_wr, s_flush, s_rdy;
    logic [63:0] s_addr, s_data;
    int          s_cred;
    int          n_push = 0;
    logic [63:0] acc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic cycle();
        logic redir, rdy, vld, rd, acc, pop;
        logic [63:0] rpc, dat, p_addr;
        logic p_req, p_wr, p_flush;
        int p_cred, c;
        redir = f_redir || pct(k_redir_pct);
        rpc   = f_redir ? f_rpc : {$urandom, $urandom};
        rdy   = !e_busy && pct(k_rdy_pct);
        vld   = e_busy && (e_lat == 0);
        dat   = vld ? e_data : {$urandom, $urandom};
        p_wr  = !f_rst && m_have && (m_cred >= 2) && !redir;
        rd    = f_rd || (k_rd_with_push ? p_wr : pct(k_rd_pct));
        rst                = f_rst;
        bus.redirect_i     = redir;
        bus.redirect_pc_i  = rpc;
        bus.icache_ready_i = rdy;
        bus.icache_valid_i = vld;
        bus.icache_data_i  = dat;
        bus.iq_rd_i        = rd;

        p_req   = !f_rst && !m_idle && !m_out && !m_have;
        p_flush = !f_rst && m_flush;
        p_cred  = f_rst ? D : m_cred;
        p_addr  = f_rst ? RESET_PC : m_pc;
        #1;
        chk("icache_req", 64'(bus.icache_req_o), 64'(p_req));
        chk("iq_wr", 64'(bus.iq_wr_o), 64'(p_wr));
        chk("iq_flush", 64'(bus.iq_flush_o), 64'(p_flush));
        chk("credits", 64'(bus.credits_o), 64'(p_cred));
        if (p_req || f_rst) chk("icache_addr", bus.icache_addr_o, p_addr);
        if (p_wr) chk("iq_data", bus.iq_data_o, m_line);
        s_req   = bus.icache_req_o;
        s_wr    = bus.iq_wr_o;
        s_flush = bus.iq_flush_o;
        s_cred  = int'(bus.credits_o);
        s_addr  = bus.icache_addr_o;
        s_data  = bus.iq_data_o;
        s_rdy   = rdy;

        @(posedge clk);
        if (f_rst) begin
            m_idle = 1'b1; m_pc = RESET_PC; m_cred = D; m_have = 1'b0;
            m_line = '0; m_out = 1'b0; m_drain = 1'b0; m_flush = 1'b0;
        end else begin
            acc = p_req && rdy;
            pop = rd && !m_flush;
            c = m_cred - (p_wr ? 2 : 0) + (pop ? 1 : 0);
            m_cred = redir ? D : ((c > D) ? D : c);
            m_idle = 1'b0;
            if (redir) begin
                m_pc    = rpc & ~64'h7;
                m_have  = 1'b0;
                m_line  = '0;
                m_flush = 1'b1;
                m_out   = (m_out && !vld) || acc;
                m_drain = m_out;
            end else begin
                m_flush = 1'b0;
                if (vld && m_out) begin
                    m_out = 1'b0;
                    if (!m_drain) begin
                        m_have = 1'b1;
                        m_line = dat;
                    end
                    m_drain = 1'b0;
                end
                if (acc) m_out = 1'b1;
                if (p_wr) begin
                    m_pc   = m_pc + 64'd8;
                    m_have = 1'b0;
                end
            end
        end

        if (s_wr) n_push++;
        if (vld) e_busy = 1'b0;
        else if (e_busy && e_lat > 0) e_lat--;
        if (s_req && rdy) begin
            e_busy = 1'b1;
            e_lat  = int'($urandom_range(k_lat_min, k_lat_max));
            e_data = k_fixed ? (k_data ^ s_addr) : {$urandom, $urandom};
            acc_q.push_back(s_addr);
        end
        @(negedge clk);
    endtask

    task automatic wait_for(input int what, input int max, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            cycle();
            case (what)
                W_WR:      hit = s_wr;
                W_REQ:     hit = s_req;
                W_WAITING: hit = m_out && !m_drain;
                default:   hit = m_have && (m_cred == 2) && !m_out;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout %s: not reached within %0d cycles", name, max);
        end
    endtask

    task automatic do_reset(input bit clear_env);
        f_rst = 1'b1;
        cycle();
        cycle();
        f_rst = 1'b0;
        if (clear_env) e_busy = 1'b0;
        acc_q.delete();
        n_push = 0;
    endtask

    task automatic directed_knobs();
        k_rdy_pct = 100; k_rd_pct = 0; k_redir_pct = 0;
        k_lat_min = 0; k_lat_max = 0; k_rd_with_push = 1'b0; k_fixed = 1'b1;
        f_rst = 1'b0; f_redir = 1'b0; f_rd = 1'b0;
    endtask

    initial begin
        int wr_seen;
        bit got;
        bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.icache_ready_i = 1'b0;
        bus.icache_valid_i = 1'b0; bus.icache_data_i = '0; bus.iq_rd_i = 1'b0;
        @(negedge clk);

        // Reset values, first fetch and first push.
        directed_knobs();
        do_reset(1'b1);
        chk("rst_credits", 64'(s_cred), 64'd8);
        chk("rst_req", 64'(s_req), 64'd0);
        chk("rst_addr", s_addr, RESET_PC);
        cycle();
        chk("post_rst_req", 64'(s_req), 64'd0);
        chk("post_rst_wr", 64'(s_wr), 64'd0);
        chk("post_rst_flush", 64'(s_flush), 64'd0);
        chk("post_rst_credits", 64'(s_cred), 64'd8);
        cycle();
        chk("first_req", 64'(s_req), 64'd1);
        chk("first_addr", s_addr, 64'd0);
        cycle();
        cycle();
        chk("first_push_wr", 64'(s_wr), 64'd1);
        chk("first_push_data", s_data, 64'hAAAA_BBBB_CCCC_DDDD);
        cycle();
        chk("credits_after_push", 64'(s_cred), 64'd6);
        chk("second_addr", s_addr, 64'd8);

        // Queue fills with no pops and the fetcher stalls holding a line.
        for (int i = 0; i < 40; i++) cycle();
        chk("push_count", 64'(n_push), 64'd4);
        chk("accepted_count", 64'(acc_q.size()), 64'd5);
        for (int i = 0; i < acc_q.size() && i < 5; i++)
            chk("accepted_addr", acc_q[i], 64'(i * 8));
        chk("stall_credits", 64'(s_cred), 64'd0);
        chk("stall_wr", 64'(s_wr), 64'd0);
        f_rd = 1'b1; cycle(); f_rd = 1'b0; cycle();
        chk("one_pop_credits", 64'(s_cred), 64'd1);
        chk("one_pop_wr", 64'(s_wr), 64'd0);
        f_rd = 1'b1; cycle(); f_rd = 1'b0; cycle();
        chk("two_pop_wr", 64'(s_wr), 64'd1);
        chk("two_pop_data", s_data, 64'hAAAA_BBBB_CCCC_DDDD ^ 64'd32);
        cycle();
        chk("two_pop_credits", 64'(s_cred), 64'd0);

        // Push and pop in the same cycle at four credits.
        directed_knobs();
        k_rd_with_push = 1'b1;
        do_reset(1'b1);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            cycle();
            got = s_wr && (s_cred == 4);
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout push_at_4: not reached");
        end
        cycle();
        chk("push_pop_credits", 64'(s_cred), 64'd3);

        // Redirect while a request is outstanding: flush, drain, refetch.
        directed_knobs();
        k_lat_min = 3; k_lat_max = 3;
        do_reset(1'b1);
        wait_for(W_WAITING, 20, "wait_state");
        f_redir = 1'b1; f_rpc = 64'h1234_5677;
        cycle();
        f_redir = 1'b0;
        cycle();
        chk("redir_flush", 64'(s_flush), 64'd1);
        chk("redir_credits", 64'(s_cred), 64'd8);
        chk("drain_req", 64'(s_req), 64'd0);
        cycle();
        chk("flush_once", 64'(s_flush), 64'd0);
        wr_seen = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (s_wr) wr_seen++;
            got = s_req;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout refetch: no request after drain");
        end
        chk("drain_no_push", 64'(wr_seen), 64'd0);
        chk("redir_addr", s_addr, 64'h1234_5670);

        // PC wraps from the top line to zero.
        directed_knobs();
        do_reset(1'b1);
        f_redir = 1'b1; f_rpc = 64'hFFFF_FFFF_FFFF_FFF8;
        cycle();
        f_redir = 1'b0;
        wait_for(W_REQ, 10, "top_req");
        chk("top_addr", s_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        wait_for(W_WR, 10, "top_push");
        wait_for(W_REQ, 10, "wrap_req");
        chk("wrap_addr", s_addr, 64'd0);

        // Reset while a push at two credits is pending.
        directed_knobs();
        do_reset(1'b1);
        wait_for(W_PUSH2, 40, "push_at_2");
        f_rst = 1'b1;
        cycle();
        chk("rst_push_wr", 64'(s_wr), 64'd0);
        chk("rst_push_credits", 64'(s_cred), 64'd8);
        chk("rst_push_addr", s_addr, RESET_PC);
        f_rst = 1'b0;
        cycle();
        chk("rst_push_after_wr", 64'(s_wr), 64'd0);
        chk("rst_push_after_req", 64'(s_req), 64'd0);
        chk("rst_push_after_flush", 64'(s_flush), 64'd0);
        wait_for(W_REQ, 10, "rst_refetch");
        chk("rst_refetch_addr", s_addr, RESET_PC);

        // Randomized traffic, including mid-fetch resets with stale responses.
        k_fixed = 1'b0;
        for (int blk = 0; blk < 4; blk++) begin
            k_rdy_pct   = int'($urandom_range(30, 100));
            k_rd_pct    = int'($urandom_range(10, 90));
            k_redir_pct = int'($urandom_range(1, 8));
            k_lat_min   = 0;
            k_lat_max   = int'($urandom_range(0, 4));
            k_rd_with_push = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                f_rst = ($urandom_range(0, 299) == 0);
                cycle();
            end
            f_rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
